// File: rtl/alu_pkg.sv
// Op codes and multiply/divide FSM states shared by the ALU and its
// iterative multiply/divide sequencer.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADDU  = 5'd0,
        OP_SUBU  = 5'd1,
        OP_SLT   = 5'd2,
        OP_SLTU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_XOR   = 5'd6,
        OP_LUI   = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRA   = 5'd9,
        OP_SRL   = 5'd10,
        OP_NOR   = 5'd11,
        OP_MULT  = 5'd16,
        OP_MULTU = 5'd17,
        OP_DIV   = 5'd18,
        OP_DIVU  = 5'd19,
        OP_MFHI  = 5'd20,
        OP_MFLO  = 5'd21,
        OP_MTHI  = 5'd22,
        OP_MTLO  = 5'd23
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [4:0] code);
        return (code == OP_MULT) || (code == OP_MULTU) ||
               (code == OP_DIV)  || (code == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Radix-2 iterative multiplier / restoring divider on operand magnitudes,
// with sign correction applied in a final FIX cycle.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_nx,
    output logic [WIDTH-1:0] lo_nx
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e          state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic               div_q, neg_a, neg_b, div0;
    logic               last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum, rem_sh, sub_diff;
    logic [2*WIDTH-1:0] full_neg;
    logic [WIDTH-1:0]   rem_neg, quo_neg;

    assign last  = (cnt == CW'(WIDTH - 1));
    assign abs_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign sub_diff = rem_sh - {1'b0, opd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = CALC;
            end
            CALC: if (last) state_nx = FIX;
            FIX: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            opd   <= '0;
            div_q <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            div0  <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}}, abs_a};
            opd   <= abs_b;
            div_q <= is_div;
            neg_a <= is_signed & a[WIDTH-1];
            neg_b <= is_signed & b[WIDTH-1];
            div0  <= is_div & (b == '0);
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (!div_q) begin
                acc <= {add_sum, acc[WIDTH-1:1]};
            end else if (!sub_diff[WIDTH]) begin
                acc <= {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Remainder follows the dividend's sign, so a zero divisor still yields hi = a
    always_comb begin
        full_neg = ~acc + 1'b1;
        rem_neg  = ~acc[2*WIDTH-1:WIDTH] + 1'b1;
        quo_neg  = ~acc[WIDTH-1:0] + 1'b1;
        if (div_q) begin
            hi_nx = neg_a ? rem_neg : acc[2*WIDTH-1:WIDTH];
            lo_nx = div0 ? '1 : ((neg_a ^ neg_b) ? quo_neg : acc[WIDTH-1:0]);
        end else begin
            {hi_nx, lo_nx} = (neg_a ^ neg_b) ? full_neg : acc;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle integer ops plus an iterative
// multiply/divide unit writing HI/LO, with a valid/ready stall handshake.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic             rdy;
    logic             accept, md_op, md_start, md_fix;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res, hi_nx, lo_nx;

    assign in_ready = rdy & ~md_busy;
    assign accept   = in_valid & in_ready;
    assign md_op    = is_muldiv(op);
    assign md_start = accept & md_op;
    assign sh       = b[SHW-1:0];

    muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_signed ((op == OP_MULT) || (op == OP_DIV)),
        .is_div    ((op == OP_DIV) || (op == OP_DIVU)),
        .a         (a),
        .b         (b),
        .busy      (md_busy),
        .done      (md_fix),
        .hi_nx     (hi_nx),
        .lo_nx     (lo_nx)
    );

    always_comb begin
        res = '0;
        case (op)
            OP_ADDU: res = a + b;
            OP_SUBU: res = a - b;
            OP_SLT:  res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: res = WIDTH'(a < b);
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_LUI:  res = b << (WIDTH / 2);
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = $unsigned($signed(a) >>> sh);
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            OP_MTHI: res = a;
            OP_MTLO: res = a;
            default: res = '0;
        endcase
    end

    // rdy keeps in_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy       <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            md_done   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            rdy       <= 1'b1;
            md_done   <= md_fix;
            out_valid <= accept & ~md_op;
            if (accept && !md_op) out <= res;
            if (md_fix) begin
                hi <= hi_nx;
                lo <= lo_nx;
            end else if (accept && op == OP_MTHI) begin
                hi <= a;
            end else if (accept && op == OP_MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32 and WIDTH=16; single-cycle
// results are checked through expected-value queues drained on out_valid.
module tb_alu_muldiv;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, md_busy, md_done;
    logic [4:0]  op;
    logic [31:0] a, b, out, hi, lo;

    logic        in_valid16, in_ready16, out_valid16, md_busy16, md_done16;
    logic [4:0]  op16;
    logic [15:0] a16, b16, out16, hi16, lo16;

    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    exp_t exp_q[$];
    exp_t exp16_q[$];

    alu_muldiv #(.WIDTH(32)) dut (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
        .op (op), .a (a), .b (b), .out_valid (out_valid), .out (out),
        .md_busy (md_busy), .md_done (md_done), .hi (hi), .lo (lo)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid16), .in_ready (in_ready16),
        .op (op16), .a (a16), .b (b16), .out_valid (out_valid16), .out (out16),
        .md_busy (md_busy16), .md_done (md_done16), .hi (hi16), .lo (lo16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_out_valid32", {31'd0, out_valid}, 32'd0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.tag, out, e.val);
            end
        end
        if (out_valid16 === 1'b1) begin
            if (exp16_q.size() == 0) check("unexpected_out_valid16", {31'd0, out_valid16}, 32'd0);
            else begin
                exp_t e;
                e = exp16_q.pop_front();
                check(e.tag, {16'd0, out16}, e.val);
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit has_out, input logic [31:0] e, input string tag);
        int n;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check({tag, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        else if (has_out) exp_q.push_back('{tag, e});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue16(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                           input bit has_out, input logic [15:0] e, input string tag);
        int n;
        @(negedge clk);
        in_valid16 = 1'b1; op16 = o; a16 = x; b16 = y;
        n = 0;
        while (in_ready16 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready16 !== 1'b1) check({tag, "_accept_timeout"}, {31'd0, in_ready16}, 32'd1);
        else if (has_out) exp16_q.push_back('{tag, {16'd0, e}});
        @(posedge clk);
        #1 in_valid16 = 1'b0;
    endtask

    task automatic wait_md(input string tag, input logic [31:0] eh, input logic [31:0] el);
        int busy_n;
        bit seen;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (md_done === 1'b1) seen = 1'b1;
            else if (md_busy === 1'b1) busy_n++;
        end
        check({tag, "_busy_cycles"}, busy_n, 32'd33);
        check({tag, "_done"}, {31'd0, seen}, 32'd1);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, md_done}, 32'd0);
    endtask

    initial begin
        int n;
        int busy_n;
        int done_n;
        bit seen;

        rst_n = 1'b0;
        in_valid = 1'b0; op = '0; a = '0; b = '0;
        in_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

        #12;
        check("rst_out", out, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_md_done", {31'd0, md_done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue(OP_ADDU, 32'hFFFF_FFFF, 32'h1,         1, 32'h0,         "addu_wrap");
        issue(OP_SUBU, 32'h0,         32'h1,         1, 32'hFFFF_FFFF, "subu_wrap");
        issue(OP_SLT,  32'hFFFF_FFFF, 32'h1,         1, 32'h1,         "slt");
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1,         1, 32'h0,         "sltu");
        issue(OP_SRA,  32'h8000_0000, 32'h24,        1, 32'hF800_0000, "sra");
        issue(OP_SRL,  32'h8000_0000, 32'h4,         1, 32'h0800_0000, "srl");
        issue(OP_SLL,  32'h3,         32'hFFFF_FFE5, 1, 32'h60,        "sll");
        issue(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, "and");
        issue(OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, "or");
        issue(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, "xor");
        issue(OP_NOR,  32'h0,         32'h0,         1, 32'hFFFF_FFFF, "nor");
        issue(OP_LUI,  32'h0,         32'h1234,      1, 32'h1234_0000, "lui");
        @(negedge clk);
        check("lui_out_valid_high", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("out_valid_one_cycle", {31'd0, out_valid}, 32'd0);

        issue(OP_MTHI, 32'h1111, 32'h0, 1, 32'h1111, "mthi");
        issue(OP_MTLO, 32'h2222, 32'h0, 1, 32'h2222, "mtlo");
        issue(5'd12,   32'h55,   32'h66, 1, 32'h0,  "undef_op");
        issue(OP_MFHI, 32'h0,    32'h0, 1, 32'h1111, "mfhi");
        issue(OP_MFLO, 32'h0,    32'h0, 1, 32'h2222, "mflo");
        @(negedge clk);
        check("undef_hi_kept", hi, 32'h1111);
        check("undef_lo_kept", lo, 32'h2222);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'h7, 0, 32'h0, "mult");
        wait_md("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(OP_MFLO, 32'h0, 32'h0, 1, 32'hFFFF_FFEB, "mflo_mult");
        issue(OP_MFHI, 32'h0, 32'h0, 1, 32'hFFFF_FFFF, "mfhi_mult");

        issue(OP_DIV,  32'hFFFF_FFF9, 32'h2, 0, 32'h0, "div");
        wait_md("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIVU, 32'h7, 32'h0, 0, 32'h0, "divu_by0");
        wait_md("divu_by0", 32'h7, 32'hFFFF_FFFF);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, "div_ovf");
        wait_md("div_ovf", 32'h0, 32'h8000_0000);
        issue(OP_DIV,  32'hFFFF_FFFB, 32'h0, 0, 32'h0, "div_neg_by0");
        wait_md("div_neg_by0", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Back-pressure: operands wiggle during CALC, then a held ADDU waits
        issue(OP_MULTU, 32'h1234_5678, 32'h0001_0000, 0, 32'h0, "bp_multu");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            op = 5'($urandom_range(0, 23));
        end
        @(negedge clk);
        in_valid = 1'b1; op = OP_ADDU; a = 32'd5; b = 32'd6;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_md_busy", {31'd0, md_busy}, 32'd1);
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_ready_with_done", {31'd0, md_done}, 32'd1);
        check("bp_hi", hi, 32'h0000_1234);
        check("bp_lo", lo, 32'h5678_0000);
        exp_q.push_back('{"bp_addu", 32'd11});
        @(posedge clk);
        #1 in_valid = 1'b0;

        // Reset asserted mid-CALC
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0, "abort_multu");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", out, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_md_busy", {31'd0, md_busy}, 32'd0);
        check("abort_md_done", {31'd0, md_done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_done === 1'b1) done_n++;
        end
        check("abort_no_done", done_n, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0, "multu_max");
        wait_md("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        // 16-bit instance
        issue16(OP_MULTU, 16'hFFFF, 16'hFFFF, 0, 16'h0, "m16");
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (md_done16 === 1'b1) seen = 1'b1;
            else if (md_busy16 === 1'b1) busy_n++;
        end
        check("m16_busy_cycles", busy_n, 32'd17);
        check("m16_done", {31'd0, seen}, 32'd1);
        check("m16_hi", {16'd0, hi16}, 32'h0000_FFFE);
        check("m16_lo", {16'd0, lo16}, 32'h0000_0001);
        issue16(OP_SLL, 16'h0001, 16'h0013, 1, 16'h0008, "sll16");

        repeat (3) @(negedge clk);
        check("queue32_drained", exp_q.size(), 32'd0);
        check("queue16_drained", exp16_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Next-generation execute-stage ALU for the MIPS150 datapath, parametrised in data width.
- Keeps the full single-cycle integer op set, now with a registered output.
- Adds an iterative multiply/divide unit that writes dedicated HI/LO registers, plus MFHI/MFLO/MTHI/MTLO.
- Uses a valid/ready handshake so the pipeline stalls while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, datapath width in bits; must be even and ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready
- op  in  5  operation code (alu_pkg)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result on out is valid this cycle (one-cycle pulse)
- out  out  WIDTH  registered result
- md_busy  out  1  multiply/divide in progress
- md_done  out  1  one-cycle pulse when HI/LO updated by MULT/DIV
- hi  out  WIDTH  HI register (observability)
- lo  out  WIDTH  LO register (observability)

Behaviour:
- Reset (rst_n low, async):
  - out=0, out_valid=0, md_busy=0, md_done=0, hi=0, lo=0, FSM=IDLE.
  - in_ready goes high the first cycle after release.
- in_ready = !md_busy. A request presented while busy is not consumed; the requester holds its inputs.
- Single-cycle ops, accepted at edge t; out and out_valid=1 from edge t+1, for one cycle:
  - ADDU, SUBU: modulo 2^WIDTH, no overflow trap.
  - SLT: signed compare, result 1/0 zero-extended. SLTU: unsigned compare, same result form.
  - AND, OR, XOR, NOR.
  - LUI: b << (WIDTH/2).
  - SLL: a << b[SHW-1:0]. SRL: logical a >> b[SHW-1:0]. SRA: arithmetic a >>> b[SHW-1:0]. Upper bits of b are ignored.
  - MFHI / MFLO: out = hi / lo.
  - MTHI / MTLO: write hi / lo from a at t+1. out_valid=1 with out=a.
  - Undefined op code: out=0, out_valid=1, hi/lo unchanged.
- Multi-cycle ops (MULT, MULTU, DIV, DIVU), accepted at edge t:
  - No out_valid is produced.
  - FSM: IDLE -> CALC (WIDTH cycles, one radix-2 shift-add or restoring-subtract step per cycle) -> FIX (sign correction, HI/LO write) -> IDLE.
  - md_busy is high from t+1 through the FIX cycle, i.e. WIDTH+1 cycles. in_ready returns high on the cycle after FIX.
  - md_done pulses in the first IDLE cycle after FIX. hi/lo already hold the new values then.
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product (signed/unsigned).
  - DIV/DIVU: lo = quotient, hi = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = a, completes in normal latency.
  - Signed DIV of most-negative by -1: lo = most-negative, hi = 0.
- hi/lo hold their previous values during CALC. Operands are captured at acceptance, so later changes to a/b have no effect.
- Reset asserted mid-operation aborts the FSM immediately. hi/lo = 0 and no md_done is issued.

Decomposition:
- Package alu_pkg:
  - 5-bit op codes: ADDU=0, SUBU=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, LUI=7, SLL=8, SRA=9, SRL=10, NOR=11, MULT=16, MULTU=17, DIV=18, DIVU=19, MFHI=20, MFLO=21, MTHI=22, MTLO=23.
  - md_state enum: IDLE, CALC, FIX.
- Sub-module muldiv_seq (parametrised WIDTH):
  - Contains the iteration counter, operand/accumulator registers and sign-fix logic.
  - Handshake with the top: start/signed/is_div in; busy, done, hi_nx, lo_nx out.

Test Plan:
- Reset then single-cycle ops, WIDTH=32: ADDU 0xFFFFFFFF+1 -> out=0 at t+1, out_valid 1 cycle. SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by b=0x24 (amount 4) -> 0xF8000000. LUI b=0x1234 -> 0x12340000.
- MULT a=-3 (0xFFFFFFFD), b=7 -> md_busy 33 cycles, md_done pulse. hi=0xFFFFFFFF, lo=0xFFFFFFEB. MFLO then returns 0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Back-pressure: issue ADDU while md_busy -> in_ready=0, no out_valid. Request accepted the cycle after FIX with correct result; a/b toggled during CALC do not alter the product.
- Reset mid-CALC (cycle 10 of MULTU 0xFFFFFFFF*0xFFFFFFFF) -> all outputs 0 asynchronously. No md_done after release. A fresh MULTU yields hi=0xFFFFFFFE, lo=0x00000001.
- WIDTH=16 instance: MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001 after 17 busy cycles. SLL 1 by b=0x0013 (amount 3) -> 0x0008.
